// File: rtl/seg_p2s.sv
// seg_p2s: frames the 64-bit segment image out MSB-first on s_clk/s_data,
// then pulses s_pen to latch the chained shift registers. One frame per
// accepted start; every output is a flop.
module seg_p2s #(
  parameter int HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] par_data,
  output logic        s_clk,
  output logic        s_data,
  output logic        s_pen,
  output logic        s_clrn,
  output logic        busy,
  output logic        done
);

  // Divider width stays at least one bit so HALF=1 still has a legal counter.
  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

  // state    | meaning
  // IDLE     | waiting for start, outputs quiet
  // SHIFT_LO | s_clk low, current bit presented on s_data
  // SHIFT_HI | s_clk high, bit held for the receiver's rising-edge sample
  // LATCH    | s_pen high for HALF cycles
  // DONE     | one-cycle done pulse, back to IDLE
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     sreg_q, sreg_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            s_clk_q, s_clk_d;
  logic            s_data_q, s_data_d;
  logic            s_pen_q, s_pen_d;
  logic            s_clrn_q, s_clrn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      s_clk_q   <= 1'b0;
      s_data_q  <= 1'b0;
      s_pen_q   <= 1'b0;
      s_clrn_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      s_clk_q   <= s_clk_d;
      s_data_q  <= s_data_d;
      s_pen_q   <= s_pen_d;
      s_clrn_q  <= s_clrn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state, shift register and phase/bit counters.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d    = par_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          sreg_d    = {sreg_q[62:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd63) ? LATCH : SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      LATCH: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they land in flops aligned with it.
  always_comb begin
    s_clk_d  = 1'b0;
    s_data_d = 1'b0;
    s_pen_d  = 1'b0;
    s_clrn_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      SHIFT_LO: begin
        s_data_d = sreg_d[63];
        busy_d   = 1'b1;
      end
      SHIFT_HI: begin
        s_clk_d  = 1'b1;
        s_data_d = sreg_d[63];
        busy_d   = 1'b1;
      end
      LATCH: begin
        s_pen_d = 1'b1;
        busy_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign s_clk  = s_clk_q;
  assign s_data = s_data_q;
  assign s_pen  = s_pen_q;
  assign s_clrn = s_clrn_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seg_p2s.sv
// Bench for seg_p2s: two instances (HALF=2 and HALF=1) checked every cycle
// against a frame-timing model, plus directed frames and corner sequences.
module tb_seg_p2s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v   = 2'b11;
  logic [1:0]  start_v = 2'b00;
  logic [63:0] pd_v [2];
  logic [1:0]  sclk_v, sdata_v, spen_v, sclrn_v, busy_v, done_v;

  seg_p2s #(.HALF(2)) u_dut_h2 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .par_data(pd_v[0]),
    .s_clk(sclk_v[0]), .s_data(sdata_v[0]), .s_pen(spen_v[0]),
    .s_clrn(sclrn_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  seg_p2s #(.HALF(1)) u_dut_h1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .par_data(pd_v[1]),
    .s_clk(sclk_v[1]), .s_data(sdata_v[1]), .s_pen(spen_v[1]),
    .s_clrn(sclrn_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  function automatic int half_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // observed outputs packed as {s_clk, s_data, s_pen, s_clrn, busy, done}
  function automatic logic [5:0] obs(input int i);
    return {sclk_v[i], sdata_v[i], spen_v[i], sclrn_v[i], busy_v[i], done_v[i]};
  endfunction

  // Expected outputs in cycle T+n of a frame carrying d, from the frame timing rules.
  function automatic logic [5:0] exp_out(input int n, input logic [63:0] d, input int h,
                                         input bit act, input bit clrn);
    int k;
    bit hi;
    if (!act) return {3'b000, clrn, 2'b00};
    if (n <= 128 * h) begin
      k  = (n - 1) / (2 * h);
      hi = (((n - 1) / h) % 2) == 1;
      return {hi, d[63 - k], 1'b0, 1'b1, 1'b1, 1'b0};
    end
    if (n <= 129 * h) return 6'b001110;
    return 6'b000101;
  endfunction

  // Reference model: frame active flag and cycle offset since the accept.
  bit          m_act  [2];
  int          m_n    [2];
  logic [63:0] m_d    [2];
  bit          m_clrn [2];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        m_act[i]  = 1'b0;
        m_clrn[i] = 1'b0;
      end else begin
        m_clrn[i] = 1'b1;
        if (m_act[i]) begin
          if (m_n[i] == 129 * half_of(i) + 1) m_act[i] = 1'b0;
          else m_n[i] = m_n[i] + 1;
        end else if (start_v[i]) begin
          m_act[i] = 1'b1;
          m_n[i]   = 1;
          m_d[i]   = pd_v[i];
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_h%0d cyc %0d", half_of(i), cyc), {58'd0, obs(i)},
            {58'd0, exp_out(m_n[i], m_d[i], half_of(i), m_act[i], m_clrn[i])});
      end
    end
  end

  // Receiver-side monitor: captures bits on s_clk rises, times s_pen/done/busy.
  logic        mon_prev  [2];
  int          rises     [2];
  int          first_rise[2];
  int          pen_cnt   [2];
  int          pen_first [2];
  int          pen_last  [2];
  int          done_cnt  [2];
  int          done_cyc  [2];
  int          busy_cnt  [2];
  logic [63:0] cap       [2];
  logic [63:0] cap_done  [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk_v[i] === 1'b1 && mon_prev[i] === 1'b0) begin
        cap[i]   = {cap[i][62:0], sdata_v[i]};
        rises[i] = rises[i] + 1;
        if (rises[i] == 1) first_rise[i] = cyc;
      end
      mon_prev[i] = sclk_v[i];
      if (spen_v[i] === 1'b1) begin
        if (pen_cnt[i] == 0) pen_first[i] = cyc;
        pen_last[i] = cyc;
        pen_cnt[i]  = pen_cnt[i] + 1;
      end
      if (busy_v[i] === 1'b1) busy_cnt[i] = busy_cnt[i] + 1;
      if (done_v[i] === 1'b1) begin
        done_cnt[i] = done_cnt[i] + 1;
        done_cyc[i] = cyc;
        cap_done[i] = cap[i];
      end
    end
  end

  task automatic clear_mon(input int i);
    rises[i] = 0; first_rise[i] = 0; pen_cnt[i] = 0; pen_first[i] = 0;
    pen_last[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0; busy_cnt[i] = 0;
    cap[i] = '0; cap_done[i] = '0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int i, input int target, input int budget);
    int c;
    c = 0;
    while (rises[i] < target && c < budget) begin
      step();
      c++;
    end
    chk($sformatf("wait_rises_%0d", target), (rises[i] >= target) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int i, input int count, input int budget);
    int c;
    c = 0;
    while (done_cnt[i] < count && c < budget) begin
      step();
      c++;
    end
    chk("wait_done", (done_cnt[i] >= count) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic run_frame(input int i, input logic [63:0] data, output int t0);
    clear_mon(i);
    pd_v[i]    = data;
    start_v[i] = 1'b1;
    t0         = cyc;
    step();
    start_v[i] = 1'b0;
    wait_done(i, 1, 400);
    step();
    step();
  endtask

  typedef struct {
    int          inst;
    logic [63:0] data;
    int          rise0;
    int          pen_lo;
    int          pen_hi;
    int          done_off;
    int          busy_n;
  } vec_t;

  vec_t        vt [4];
  int          t0;
  int          prev_done;
  logic [63:0] d;

  initial begin
    pd_v[0] = '0;
    pd_v[1] = '0;
    vt[0] = '{0, 64'h8000_0000_0000_0001, 3, 257, 258, 259, 258};
    vt[1] = '{0, 64'hC0F9_A4B0_9992_82F8, 3, 257, 258, 259, 258};
    vt[2] = '{1, 64'hAAAA_AAAA_AAAA_AAAA, 2, 129, 129, 130, 129};
    vt[3] = '{1, 64'h0123_4567_89AB_CDEF, 2, 129, 129, 130, 129};

    // reset held three cycles, then released
    for (int r = 0; r < 3; r++) begin
      step();
      for (int i = 0; i < 2; i++) chk($sformatf("in_reset_%0d", i), {58'd0, obs(i)}, 64'h00);
    end
    rst_v = 2'b00;
    step();
    for (int i = 0; i < 2; i++) chk($sformatf("after_reset_%0d", i), {58'd0, obs(i)}, 64'h04);
    step();

    // directed single frames
    for (int v = 0; v < 4; v++) begin
      run_frame(vt[v].inst, vt[v].data, t0);
      chk($sformatf("v%0d_bits", v), cap[vt[v].inst], vt[v].data);
      chk($sformatf("v%0d_rises", v), 64'(rises[vt[v].inst]), 64'd64);
      chk($sformatf("v%0d_first_rise", v), 64'(first_rise[vt[v].inst] - t0), 64'(vt[v].rise0));
      chk($sformatf("v%0d_pen_first", v), 64'(pen_first[vt[v].inst] - t0), 64'(vt[v].pen_lo));
      chk($sformatf("v%0d_pen_last", v), 64'(pen_last[vt[v].inst] - t0), 64'(vt[v].pen_hi));
      chk($sformatf("v%0d_done_at", v), 64'(done_cyc[vt[v].inst] - t0), 64'(vt[v].done_off));
      chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt[vt[v].inst]), 64'd1);
      chk($sformatf("v%0d_busy_cnt", v), 64'(busy_cnt[vt[v].inst]), 64'(vt[v].busy_n));
    end

    // continuous refresh with start held high
    clear_mon(0);
    pd_v[0]    = 64'hC0F9_A4B0_9992_82F8;
    start_v[0] = 1'b1;
    prev_done  = 0;
    for (int f = 0; f < 3; f++) begin
      wait_done(0, f + 1, 400);
      chk($sformatf("refresh_bits_%0d", f), cap_done[0], 64'hC0F9_A4B0_9992_82F8);
      if (f > 0) chk($sformatf("refresh_period_%0d", f), 64'(done_cyc[0] - prev_done), 64'd260);
      prev_done = done_cyc[0];
    end
    start_v[0] = 1'b0;
    repeat (300) step();
    chk("refresh_stop", 64'(done_cnt[0]), 64'd3);

    // par_data change and start pulse mid-frame are both ignored
    clear_mon(0);
    pd_v[0]    = '0;
    start_v[0] = 1'b1;
    t0         = cyc;
    step();
    start_v[0] = 1'b0;
    wait_rises(0, 10, 100);
    pd_v[0] = '1;
    wait_rises(0, 30, 200);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    wait_done(0, 1, 400);
    chk("ignore_bits", cap_done[0], 64'd0);
    chk("ignore_done_at", 64'(done_cyc[0] - t0), 64'd259);
    repeat (300) step();
    chk("ignore_done_cnt", 64'(done_cnt[0]), 64'd1);
    pd_v[0] = '0;

    // reset during bit 20 aborts the frame without a latch strobe
    clear_mon(0);
    pd_v[0]    = 64'h5A5A_F00F_1234_8765;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    wait_rises(0, 21, 200);
    rst_v[0] = 1'b1;
    step();
    chk("midrst_outputs", {58'd0, obs(0)}, 64'h00);
    rst_v[0] = 1'b0;
    clear_mon(0);
    repeat (300) step();
    chk("midrst_no_pen", 64'(pen_cnt[0]), 64'd0);
    chk("midrst_no_done", 64'(done_cnt[0]), 64'd0);
    run_frame(0, 64'h0F1E_2D3C_4B5A_6978, t0);
    chk("midrst_new_bits", cap[0], 64'h0F1E_2D3C_4B5A_6978);
    chk("midrst_new_rises", 64'(rises[0]), 64'd64);
    chk("midrst_new_done_at", 64'(done_cyc[0] - t0), 64'd259);

    // randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_v[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) begin
          d = {$urandom, $urandom};
          pd_v[i] = d;
        end
        rst_v[i] = ($urandom_range(0, 999) == 0);
      end
      step();
    end
    rst_v   = 2'b00;
    start_v = 2'b00;
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_p2s.md
# seg_p2s

Parallel-to-serial shifter that takes the 64-bit segment image from the hex-to-segment encoder and drives the board's chained serial segment shift registers. It runs one frame per accepted `start`: 64 bits shifted out, then an output latch strobe. It sits directly downstream of the segment encoder, between its `SEG_TXT` bus and the board's seven-segment serial pins. All outputs are registered.

## Interface
- `HALF`, default 2: system-clock cycles per half period of `s_clk`; legal range ≥1.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  frame request; level-sampled only in IDLE.
- `par_data`  in  64  segment image; digit 7 is in [7:0], digit 0 in [63:56]; captured on accept.
- `s_clk`  out  1  serial shift clock; the shift registers sample on its rising edge.
- `s_data`  out  1  serial data; MSB first.
- `s_pen`  out  1  output-latch strobe, active-high.
- `s_clrn`  out  1  shift-register clear, active-low.
- `busy`  out  1  high while a frame is in progress (SHIFT_LO, SHIFT_HI, LATCH).
- `done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Internal registers:
  - state: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
  - 64-bit `sreg`.
  - 6-bit `bit_cnt`.
  - Divider counter `div_cnt`, counting 0..HALF-1.
- IDLE, with `start`=1:
  - Load `sreg`←`par_data`, `bit_cnt`←0, `div_cnt`←0.
  - Go to SHIFT_LO.
- SHIFT_LO:
  - `s_clk`=0, `s_data`=`sreg[63]`.
  - After HALF cycles, go to SHIFT_HI.
- SHIFT_HI:
  - `s_clk`=1, `s_data` held.
  - After HALF cycles: `sreg`←`sreg`<<1 and `bit_cnt`+1.
  - If `bit_cnt` was 63, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - `s_clk`=0, `s_data`=0, `s_pen`=1.
  - Lasts HALF cycles, then go to DONE.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - Then go to IDLE, unconditionally.
- `start` is ignored outside IDLE.
  - `start` held high gives continuous refresh, with one IDLE cycle between frames.
- `par_data` changes after the accept do not affect the frame in flight.
- Outside SHIFT states: `s_clk`=0 and `s_data`=0.
- Outside LATCH: `s_pen`=0.
- `s_clrn`: 0 during reset; 1 from the first cycle after `rst` deasserts.
- `rst` mid-frame aborts immediately; no partial latch strobe is issued.

## Timing
- Reset values: state IDLE; `s_clk`=0, `s_data`=0, `s_pen`=0, `s_clrn`=0, `busy`=0, `done`=0; `sreg`=0, `bit_cnt`=0, `div_cnt`=0.
- Cycle numbering: `start` is sampled at the end of IDLE cycle T.
  - T+1 is the first SHIFT_LO cycle; `busy` rises at T+1.
  - Bit k (k=0..63) is `par_data[63-k]`.
  - `s_clk` rises at cycle T+1+(2k+1)·HALF.
  - The shift phase spans 128·HALF cycles.
  - LATCH spans T+1+128·HALF .. T+128·HALF+HALF.
  - `done` is asserted at T+1+129·HALF.
- Frame period with `start` held high: 129·HALF+2 cycles.
  - HALF=2: 260 cycles.
  - HALF=1: 131 cycles.
- `bit_cnt` wraps only by leaving SHIFT_HI at 63; it is never incremented past 63.

## Test plan
- Reset behaviour: hold `rst` 3 cycles, then release.
  - During reset: all outputs at their reset values, `s_clrn`=0.
  - Cycle after release: `s_clrn`=1, other outputs unchanged.
- Single frame: HALF=2, `par_data`=64'h8000_0000_0000_0001, 1-cycle `start` at T.
  - Bits captured on `s_clk` rising edges: 1, then 62 zeros, then 1.
  - First `s_clk` rise at T+3.
  - `s_pen`=1 at T+257..T+258.
  - `done`=1 only at T+259; `busy`=1 from T+1 to T+258.
- Continuous refresh: `start` held high with `par_data`=64'hC0F9_A4B0_9992_82F8.
  - Successive `done` pulses exactly 260 cycles apart.
  - Each frame reproduces the pattern MSB-first.
- Capture and ignore rules:
  - Change `par_data` to all ones at bit 10 of a frame whose captured image is all zeros: frame stays all zeros.
  - Pulse `start` at bit 30: no effect; exactly one `done`.
- Mid-frame reset: assert `rst` during bit 20.
  - Next cycle: reset values.
  - No `s_pen` pulse follows.
  - A new `start` yields a full 64-bit frame and `done` at T+259.
- HALF=1: `par_data`=64'hAAAA_AAAA_AAAA_AAAA, single `start`.
  - Alternating 1/0 stream, `s_clk` toggling every cycle.
  - `s_pen` high at T+129 only.
  - `done` at T+130.
